// File: rtl/uart_sys_pkg.sv
// Shared definitions for the UART system: command opcodes, fixed operand
// register addresses and the frame decoder state encoding.
package uart_sys_pkg;

  // Command bytes that open a frame
  localparam logic [7:0] CMD_RF_WR  = 8'hAA;
  localparam logic [7:0] CMD_RF_RD  = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP = 8'hCC;
  localparam logic [7:0] CMD_ALU_NO = 8'hDD;

  // Register-file slots that receive ALU operands A and B
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;

  // Frame decoder states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    OPA     = 3'd4,
    OPB     = 3'd5,
    FUN     = 3'd6
  } state_e;

  // States in which the ALU clock must already be running
  function automatic logic alu_active(input state_e st);
    return (st == OPA) || (st == OPB) || (st == FUN);
  endfunction

endpackage

// File: rtl/rx_frame_decoder.sv
// Decodes command frames arriving byte-by-byte from the UART receiver into
// register-file write/read pulses and ALU operation requests. All outputs
// are registered, so every pulse appears one cycle after its strobe.
module rx_frame_decoder
  import uart_sys_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  input  logic                  RX_ERR,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  output logic                  ALU_EN,
  output logic [3:0]            ALU_FUN,
  output logic                  CLK_GATE_EN,
  output logic                  FRAME_ERR
);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;       // address byte held until the data byte arrives
  logic                    wr_en_q, wr_en_d;
  logic                    rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]   rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0]   rf_wdata_q, rf_wdata_d;
  logic                    alu_en_q, alu_en_d;
  logic [3:0]              alu_fun_q, alu_fun_d;
  logic                    gate_q, gate_d;
  logic                    ferr_q, ferr_d;

  // Next-state and next-output decode; only a valid strobe can move anything
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    alu_en_d   = 1'b0;
    ferr_d     = 1'b0;
    rf_addr_d  = rf_addr_q;
    rf_wdata_d = rf_wdata_q;
    alu_fun_d  = alu_fun_q;

    if (RX_D_VLD) begin
      if (RX_ERR) begin
        // Corrupted byte: drop it and the frame it belonged to
        ferr_d  = 1'b1;
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            // Unknown bytes are silently ignored, they are not frame errors
            if (RX_P_DATA == DATA_WIDTH'(CMD_RF_WR))       state_d = WR_ADDR;
            else if (RX_P_DATA == DATA_WIDTH'(CMD_RF_RD))  state_d = RD_ADDR;
            else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_OP)) state_d = OPA;
            else if (RX_P_DATA == DATA_WIDTH'(CMD_ALU_NO)) state_d = FUN;
          end
          WR_ADDR: begin
            addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
            state_d = WR_DATA;
          end
          WR_DATA: begin
            wr_en_d    = 1'b1;
            rf_addr_d  = addr_q;
            rf_wdata_d = RX_P_DATA;
            state_d    = IDLE;
          end
          RD_ADDR: begin
            rd_en_d   = 1'b1;
            rf_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
            state_d   = IDLE;
          end
          OPA: begin
            wr_en_d    = 1'b1;
            rf_addr_d  = ADDR_WIDTH'(OPA_ADDR);
            rf_wdata_d = RX_P_DATA;
            state_d    = OPB;
          end
          OPB: begin
            wr_en_d    = 1'b1;
            rf_addr_d  = ADDR_WIDTH'(OPB_ADDR);
            rf_wdata_d = RX_P_DATA;
            state_d    = FUN;
          end
          FUN: begin
            alu_en_d  = 1'b1;
            alu_fun_d = RX_P_DATA[3:0];
            state_d   = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    // Clock gate opens with the ALU states and stays open for the ALU_EN cycle
    gate_d = alu_active(state_d) || alu_en_d;
  end

  // State and output registers; reset clears everything including held data
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      rf_addr_q  <= '0;
      rf_wdata_q <= '0;
      alu_en_q   <= 1'b0;
      alu_fun_q  <= '0;
      gate_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      rf_addr_q  <= rf_addr_d;
      rf_wdata_q <= rf_wdata_d;
      alu_en_q   <= alu_en_d;
      alu_fun_q  <= alu_fun_d;
      gate_q     <= gate_d;
      ferr_q     <= ferr_d;
    end
  end

  assign RF_WrEn     = wr_en_q;
  assign RF_RdEn     = rd_en_q;
  assign RF_Address  = rf_addr_q;
  assign RF_WrData   = rf_wdata_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = gate_q;
  assign FRAME_ERR   = ferr_q;

endmodule

// File: tb/tb_rx_frame_decoder.sv
// Directed, table-driven bench for rx_frame_decoder.
module tb_rx_frame_decoder;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = '0;
  logic       RX_D_VLD = 1'b0;
  logic       RX_ERR = 1'b0;
  logic       RF_WrEn, RF_RdEn, ALU_EN, CLK_GATE_EN, FRAME_ERR;
  logic [3:0] RF_Address, ALU_FUN;
  logic [7:0] RF_WrData;

  int tests = 0;
  int fails = 0;

  rx_frame_decoder #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RX_ERR(RX_ERR), .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn),
    .RF_Address(RF_Address), .RF_WrData(RF_WrData), .ALU_EN(ALU_EN),
    .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] d;
    logic       v;
    logic       e;
    logic       wr;
    logic       rd;
    logic [3:0] addr;
    logic [7:0] wd;
    logic       alu;
    logic [3:0] fun;
    logic       gate;
    logic       ferr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [7:0] d, logic v, logic e, logic wr, logic rd,
                              logic [3:0] addr, logic [7:0] wd, logic alu,
                              logic [3:0] fun, logic gate, logic ferr);
    vec_t r;
    r.d = d; r.v = v; r.e = e; r.wr = wr; r.rd = rd; r.addr = addr; r.wd = wd;
    r.alu = alu; r.fun = fun; r.gate = gate; r.ferr = ferr;
    return r;
  endfunction

  function automatic logic [20:0] pack_exp(vec_t x);
    return {x.wr, x.rd, x.addr, x.wd, x.alu, x.fun, x.gate, x.ferr};
  endfunction

  function automatic logic [20:0] pack_act();
    return {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, FRAME_ERR};
  endfunction

  task automatic check(string name, logic [20:0] exp);
    logic [20:0] act;
    act = pack_act();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {wr,rd,addr,wd,alu,fun,gate,ferr}=%06h expected %06h", name, act, exp);
    end
  endtask

  // Drive one cycle of input, then check the registered outputs after the edge
  task automatic step(string name, vec_t x);
    @(negedge CLK);
    RX_P_DATA = x.d;
    RX_D_VLD  = x.v;
    RX_ERR    = x.e;
    @(posedge CLK);
    #1;
    check(name, pack_exp(x));
  endtask

  int alu_pulses;

  initial begin
    // Table: inputs for one cycle, outputs expected after that cycle's edge
    //               d      v  e  wr rd addr wd     alu fun  gate ferr
    vecs.push_back(mk(8'hAA, 1, 0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0)); // write frame
    vecs.push_back(mk(8'h05, 1, 0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    vecs.push_back(mk(8'h3C, 1, 0, 1, 0, 4'h5, 8'h3C, 0, 4'h0, 0, 0));
    vecs.push_back(mk(8'h00, 0, 0, 0, 0, 4'h5, 8'h3C, 0, 4'h0, 0, 0));
    vecs.push_back(mk(8'hBB, 1, 0, 0, 0, 4'h5, 8'h3C, 0, 4'h0, 0, 0)); // read frame
    vecs.push_back(mk(8'h0A, 1, 0, 0, 1, 4'hA, 8'h3C, 0, 4'h0, 0, 0));
    vecs.push_back(mk(8'hCC, 1, 0, 0, 0, 4'hA, 8'h3C, 0, 4'h0, 1, 0)); // ALU frame
    vecs.push_back(mk(8'h12, 1, 0, 1, 0, 4'h0, 8'h12, 0, 4'h0, 1, 0));
    vecs.push_back(mk(8'h34, 1, 0, 1, 0, 4'h1, 8'h34, 0, 4'h0, 1, 0));
    vecs.push_back(mk(8'h03, 1, 0, 0, 0, 4'h1, 8'h34, 1, 4'h3, 1, 0));
    vecs.push_back(mk(8'h00, 0, 0, 0, 0, 4'h1, 8'h34, 0, 4'h3, 0, 0));
    vecs.push_back(mk(8'hAA, 1, 0, 0, 0, 4'h1, 8'h34, 0, 4'h3, 0, 0)); // aborted write
    vecs.push_back(mk(8'h05, 1, 0, 0, 0, 4'h1, 8'h34, 0, 4'h3, 0, 0));
    vecs.push_back(mk(8'h3C, 1, 1, 0, 0, 4'h1, 8'h34, 0, 4'h3, 0, 1));
    vecs.push_back(mk(8'hBB, 1, 0, 0, 0, 4'h1, 8'h34, 0, 4'h3, 0, 0)); // recovery read
    vecs.push_back(mk(8'h02, 1, 0, 0, 1, 4'h2, 8'h34, 0, 4'h3, 0, 0));
    vecs.push_back(mk(8'h55, 1, 0, 0, 0, 4'h2, 8'h34, 0, 4'h3, 0, 0)); // unknown command
    vecs.push_back(mk(8'h00, 0, 0, 0, 0, 4'h2, 8'h34, 0, 4'h3, 0, 0));
    vecs.push_back(mk(8'hDD, 1, 0, 0, 0, 4'h2, 8'h34, 0, 4'h3, 1, 0)); // back-to-back DD,01
    vecs.push_back(mk(8'h01, 1, 0, 0, 0, 4'h2, 8'h34, 1, 4'h1, 1, 0));
    vecs.push_back(mk(8'hAA, 0, 1, 0, 0, 4'h2, 8'h34, 0, 4'h1, 0, 0)); // ignored without strobe
    vecs.push_back(mk(8'hCC, 1, 0, 0, 0, 4'h2, 8'h34, 0, 4'h1, 1, 0)); // partial frame waits
    vecs.push_back(mk(8'h99, 0, 0, 0, 0, 4'h2, 8'h34, 0, 4'h1, 1, 0));
    vecs.push_back(mk(8'h99, 0, 1, 0, 0, 4'h2, 8'h34, 0, 4'h1, 1, 0));
    vecs.push_back(mk(8'h77, 1, 1, 0, 0, 4'h2, 8'h34, 0, 4'h1, 0, 1)); // abort in OPA
    vecs.push_back(mk(8'h00, 0, 0, 0, 0, 4'h2, 8'h34, 0, 4'h1, 0, 0));

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("reset_state", 21'h0);
    @(negedge CLK);
    RST = 1'b1;

    foreach (vecs[i]) step($sformatf("vec%0d", i), vecs[i]);

    // Mid-frame reset: DD opens a frame, reset clears it asynchronously
    step("mf_dd", mk(8'hDD, 1, 0, 0, 0, 4'h2, 8'h34, 0, 4'h1, 1, 0));
    @(negedge CLK);
    RX_D_VLD = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    check("async_reset_clears", 21'h0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    alu_pulses = 0;
    step("mf_after_release", mk(8'h00, 0, 0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 0, 0));
    alu_pulses += int'(ALU_EN);
    step("mf_dd2", mk(8'hDD, 1, 0, 0, 0, 4'h0, 8'h00, 0, 4'h0, 1, 0));
    alu_pulses += int'(ALU_EN);
    step("mf_fun7", mk(8'h07, 1, 0, 0, 0, 4'h0, 8'h00, 1, 4'h7, 1, 0));
    alu_pulses += int'(ALU_EN);
    step("mf_idle", mk(8'h00, 0, 0, 0, 0, 4'h0, 8'h00, 0, 4'h7, 0, 0));
    alu_pulses += int'(ALU_EN);
    tests++;
    if (alu_pulses != 1) begin
      fails++;
      $display("FAIL mf_alu_pulse_count: got %0d expected 1", alu_pulses);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
